// File: rtl/control_unit.sv
// Main decoder: turns the 6-bit instruction opcode into registered datapath
// control strobes. Decode is captured on an enabled rising edge (one-cycle
// latency); a low enable freezes every output. Opcodes outside the supported
// set decode to an all-zero NOP, including the forwarded ALU opcode.
module control_unit (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [5:0] i_opcode,
  output logic       o_reg_dest,
  output logic [5:0] o_alu_op,
  output logic       o_alu_src,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_branch,
  output logic       o_reg_write,
  output logic       o_mem_to_reg,
  output logic       o_byte_en,
  output logic       o_halfword_en,
  output logic       o_word_en
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h22;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LWU   = 6'h24;
  localparam logic [5:0] OP_LBU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  logic       regDest_d,    regDest_q;
  logic [5:0] aluOp_d,      aluOp_q;
  logic       aluSrc_d,     aluSrc_q;
  logic       memRead_d,    memRead_q;
  logic       memWrite_d,   memWrite_q;
  logic       branch_d,     branch_q;
  logic       regWrite_d,   regWrite_q;
  logic       memToReg_d,   memToReg_q;
  logic       byteEn_d,     byteEn_q;
  logic       halfwordEn_d, halfwordEn_q;
  logic       wordEn_d,     wordEn_q;

  // Combinational decode of the opcode; everything defaults to the NOP pattern
  // so unknown opcodes fall through with no side effects.
  always_comb begin
    regDest_d    = 1'b0;
    aluOp_d      = 6'h00;
    aluSrc_d     = 1'b0;
    memRead_d    = 1'b0;
    memWrite_d   = 1'b0;
    branch_d     = 1'b0;
    regWrite_d   = 1'b0;
    memToReg_d   = 1'b0;
    byteEn_d     = 1'b0;
    halfwordEn_d = 1'b0;
    wordEn_d     = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        aluOp_d    = i_opcode;
        regDest_d  = 1'b1;
        regWrite_d = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        aluOp_d  = i_opcode;
        branch_d = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        aluOp_d    = i_opcode;
        aluSrc_d   = 1'b1;
        regWrite_d = 1'b1;
      end
      OP_LB, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LBU: begin
        aluOp_d      = i_opcode;
        aluSrc_d     = 1'b1;
        memRead_d    = 1'b1;
        regWrite_d   = 1'b1;
        memToReg_d   = 1'b1;
        byteEn_d     = (i_opcode == OP_LB)  || (i_opcode == OP_LBU);
        halfwordEn_d = (i_opcode == OP_LH)  || (i_opcode == OP_LHU);
        wordEn_d     = (i_opcode == OP_LW)  || (i_opcode == OP_LWU);
      end
      OP_SB, OP_SH, OP_SW: begin
        aluOp_d      = i_opcode;
        aluSrc_d     = 1'b1;
        memWrite_d   = 1'b1;
        byteEn_d     = (i_opcode == OP_SB);
        halfwordEn_d = (i_opcode == OP_SH);
        wordEn_d     = (i_opcode == OP_SW);
      end
      default: begin
        aluOp_d = 6'h00;
      end
    endcase
  end

  // Output registers: reset clears immediately, enable gates the capture of a new decode.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      regDest_q    <= 1'b0;
      aluOp_q      <= 6'h00;
      aluSrc_q     <= 1'b0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      branch_q     <= 1'b0;
      regWrite_q   <= 1'b0;
      memToReg_q   <= 1'b0;
      byteEn_q     <= 1'b0;
      halfwordEn_q <= 1'b0;
      wordEn_q     <= 1'b0;
    end else if (i_enable) begin
      regDest_q    <= regDest_d;
      aluOp_q      <= aluOp_d;
      aluSrc_q     <= aluSrc_d;
      memRead_q    <= memRead_d;
      memWrite_q   <= memWrite_d;
      branch_q     <= branch_d;
      regWrite_q   <= regWrite_d;
      memToReg_q   <= memToReg_d;
      byteEn_q     <= byteEn_d;
      halfwordEn_q <= halfwordEn_d;
      wordEn_q     <= wordEn_d;
    end
  end

  assign o_reg_dest    = regDest_q;
  assign o_alu_op      = aluOp_q;
  assign o_alu_src     = aluSrc_q;
  assign o_mem_read    = memRead_q;
  assign o_mem_write   = memWrite_q;
  assign o_branch      = branch_q;
  assign o_reg_write   = regWrite_q;
  assign o_mem_to_reg  = memToReg_q;
  assign o_byte_en     = byteEn_q;
  assign o_halfword_en = halfwordEn_q;
  assign o_word_en     = wordEn_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: a table of directed opcode vectors with
// hand-written expected control words, plus sequences covering reset timing
// and the enable hold behaviour.
module tb_control_unit;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [5:0] opcode;
  logic       regDest;
  logic [5:0] aluOp;
  logic       aluSrc;
  logic       memRead;
  logic       memWrite;
  logic       branch;
  logic       regWrite;
  logic       memToReg;
  logic       byteEn;
  logic       halfwordEn;
  logic       wordEn;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        en;
    logic [5:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  control_unit dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_opcode      (opcode),
    .o_reg_dest    (regDest),
    .o_alu_op      (aluOp),
    .o_alu_src     (aluSrc),
    .o_mem_read    (memRead),
    .o_mem_write   (memWrite),
    .o_branch      (branch),
    .o_reg_write   (regWrite),
    .o_mem_to_reg  (memToReg),
    .o_byte_en     (byteEn),
    .o_halfword_en (halfwordEn),
    .o_word_en     (wordEn)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Control word layout: {regDest, aluOp[5:0], aluSrc, memRead, memWrite,
  // branch, regWrite, memToReg, byteEn, halfwordEn, wordEn}
  function automatic logic [15:0] mkExp(input logic rd, input logic [5:0] op,
                                        input logic src, input logic mr, input logic mw,
                                        input logic br, input logic rw, input logic m2r,
                                        input logic [2:0] size);
    return {rd, op, src, mr, mw, br, rw, m2r, size};
  endfunction

  function automatic logic [15:0] actual();
    return {regDest, aluOp, aluSrc, memRead, memWrite, branch, regWrite, memToReg,
            byteEn, halfwordEn, wordEn};
  endfunction

  // Drive inputs on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic en, input logic [5:0] op);
    @(negedge clock);
    enable = en;
    opcode = op;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = actual();
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %04h expected %04h", name, act, exp);
    end
    total++;
    if ((memRead && memWrite) || (regWrite && memWrite)) begin
      bad++;
      $display("[TB] FAIL %s_exclusive: got mr=%0b mw=%0b rw=%0b expected no overlap",
               name, memRead, memWrite, regWrite);
    end
  endtask

  initial begin
    logic [15:0] zero;
    logic [15:0] andiExp;
    zero    = 16'h0000;
    andiExp = mkExp(1'b0, 6'h0c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);

    vecs.push_back('{"rtype", 1'b1, 6'h00, mkExp(1, 6'h00, 0, 0, 0, 0, 1, 0, 3'b000)});
    vecs.push_back('{"beq",   1'b1, 6'h04, mkExp(0, 6'h04, 0, 0, 0, 1, 0, 0, 3'b000)});
    vecs.push_back('{"bne",   1'b1, 6'h05, mkExp(0, 6'h05, 0, 0, 0, 1, 0, 0, 3'b000)});
    vecs.push_back('{"addi",  1'b1, 6'h08, mkExp(0, 6'h08, 1, 0, 0, 0, 1, 0, 3'b000)});
    vecs.push_back('{"slti",  1'b1, 6'h0a, mkExp(0, 6'h0a, 1, 0, 0, 0, 1, 0, 3'b000)});
    vecs.push_back('{"andi",  1'b1, 6'h0c, mkExp(0, 6'h0c, 1, 0, 0, 0, 1, 0, 3'b000)});
    vecs.push_back('{"ori",   1'b1, 6'h0d, mkExp(0, 6'h0d, 1, 0, 0, 0, 1, 0, 3'b000)});
    vecs.push_back('{"xori",  1'b1, 6'h0e, mkExp(0, 6'h0e, 1, 0, 0, 0, 1, 0, 3'b000)});
    vecs.push_back('{"lui",   1'b1, 6'h0f, mkExp(0, 6'h0f, 1, 0, 0, 0, 1, 0, 3'b000)});
    vecs.push_back('{"lb",    1'b1, 6'h20, mkExp(0, 6'h20, 1, 1, 0, 0, 1, 1, 3'b100)});
    vecs.push_back('{"lh",    1'b1, 6'h21, mkExp(0, 6'h21, 1, 1, 0, 0, 1, 1, 3'b010)});
    vecs.push_back('{"lhu",   1'b1, 6'h22, mkExp(0, 6'h22, 1, 1, 0, 0, 1, 1, 3'b010)});
    vecs.push_back('{"lw",    1'b1, 6'h23, mkExp(0, 6'h23, 1, 1, 0, 0, 1, 1, 3'b001)});
    vecs.push_back('{"lwu",   1'b1, 6'h24, mkExp(0, 6'h24, 1, 1, 0, 0, 1, 1, 3'b001)});
    vecs.push_back('{"lbu",   1'b1, 6'h25, mkExp(0, 6'h25, 1, 1, 0, 0, 1, 1, 3'b100)});
    vecs.push_back('{"sb",    1'b1, 6'h28, mkExp(0, 6'h28, 1, 0, 1, 0, 0, 0, 3'b100)});
    vecs.push_back('{"sh",    1'b1, 6'h29, mkExp(0, 6'h29, 1, 0, 1, 0, 0, 0, 3'b010)});
    vecs.push_back('{"sw",    1'b1, 6'h2b, mkExp(0, 6'h2b, 1, 0, 1, 0, 0, 0, 3'b001)});
    vecs.push_back('{"unk3f", 1'b1, 6'h3f, zero});
    vecs.push_back('{"unk01", 1'b1, 6'h01, zero});
    vecs.push_back('{"lw2",   1'b1, 6'h23, mkExp(0, 6'h23, 1, 1, 0, 0, 1, 1, 3'b001)});
    vecs.push_back('{"unk2a", 1'b1, 6'h2a, zero});
    vecs.push_back('{"unk09", 1'b1, 6'h09, zero});
    vecs.push_back('{"unk10", 1'b1, 6'h10, zero});

    // Reset for two clocks with enable low.
    reset  = 1'b1;
    enable = 1'b0;
    opcode = 6'h00;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("reset_hold", zero);
    @(negedge clock);
    reset = 1'b0;

    // Table-driven sweep.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].op);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Enable hold: load ANDI, freeze, change opcode underneath, then release with 0x3f.
    applyStimulus(1'b1, 6'h0c);
    checkOutput("hold_load_andi", andiExp);
    applyStimulus(1'b0, 6'h3f);
    checkOutput("hold_en0_a", andiExp);
    applyStimulus(1'b0, 6'h00);
    checkOutput("hold_en0_b", andiExp);
    applyStimulus(1'b1, 6'h3f);
    checkOutput("hold_release_nop", zero);

    // Asynchronous reset mid-stream: assert between edges, check before the next edge.
    applyStimulus(1'b1, 6'h23);
    checkOutput("pre_async_lw", mkExp(0, 6'h23, 1, 1, 0, 0, 1, 1, 3'b001));
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_immediate", zero);
    @(posedge clock);
    #1;
    checkOutput("reset_overrides_enable", zero);

    // First enabled edge after release loads the current opcode.
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b1;
    opcode = 6'h00;
    @(posedge clock);
    #1;
    checkOutput("post_reset_rtype", mkExp(1, 6'h00, 0, 0, 0, 0, 1, 0, 3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
